trace_merge_unit: RTL and testbench

Multi-channel trace collection front end. It is the generalised successor to the single-stream trace top. It accepts fixed-width trace records from NUM_CHANNELS independent producers, such as pipeline-stage trackers, each on its own valid/ready port. Each record is stamped with a free-running cycle timestamp and buffered per channel, then merged round-robin onto one output stream. Repeated identical records on any channel put the unit into a capture lock.

---
 rtl/trace_merge_unit_pkg.sv | 31 +++
 rtl/trace_merge_unit_if.sv | 27 ++
 rtl/trace_merge_unit_fifo.sv | 59 +++++
 rtl/trace_merge_unit.sv | 217 +++++++++++++++++++++
 tb/tb_trace_merge_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_merge_unit_pkg.sv
// Shared types and helpers for the trace merge unit.
// The record layout {record, timestamp} matches the per-channel FIFO word.
package gouram_datatypes;

    localparam int TRACE_RECORD_W = 64;
    localparam int TRACE_TS_W     = 32;
    localparam int MAX_CHANNELS   = 8;

    typedef struct packed {
        logic [TRACE_RECORD_W-1:0] record;
        logic [TRACE_TS_W-1:0]     timestamp;
    } trace_entry_t;

    // Round-robin search start; wide enough for the maximum channel count.
    typedef logic [2:0] arb_ptr_t;

    // Returns {found, index} of the first set request at or after start, wrapping at n.
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input arb_ptr_t start, input int n);
        logic [3:0] pick;
        int         idx;
        pick = 4'd0;
        for (int k = 0; k < MAX_CHANNELS; k++) begin
            idx = (int'(start) + k) % n;
            if ((k < n) && !pick[3] && req[idx[2:0]]) begin
                pick = {1'b1, idx[2:0]};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/trace_merge_unit_if.sv
// Producer-side and merged-output handshake bundle of the trace merge unit.
interface trace_merge_unit_if #(
    parameter int NUM_CHANNELS    = 2,
    parameter int RECORD_WIDTH    = 64,
    parameter int TIMESTAMP_WIDTH = 32
);
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [NUM_CHANNELS-1:0]              ch_valid;
    logic [NUM_CHANNELS-1:0]              ch_ready;
    logic [NUM_CHANNELS*RECORD_WIDTH-1:0] ch_data;
    logic                                 trace_valid;
    logic                                 trace_ready;
    logic [RECORD_WIDTH-1:0]              trace_data;
    logic [CH_W-1:0]                      trace_channel;
    logic [TIMESTAMP_WIDTH-1:0]           trace_timestamp;

    modport master (
        output ch_valid, ch_data, trace_ready,
        input  ch_ready, trace_valid, trace_data, trace_channel, trace_timestamp
    );

    modport slave (
        input  ch_valid, ch_data, trace_ready,
        output ch_ready, trace_valid, trace_data, trace_channel, trace_timestamp
    );
endinterface

// File: rtl/trace_merge_unit_fifo.sv
// Single-clock per-channel FIFO with registered occupancy count.
// Read data is presented combinationally from the head entry.
module trace_channel_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_q];

    // Pointer and occupancy update
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        wr_d      = do_push_s ? wr_q + AW'(1) : wr_q;
        rd_d      = do_pop_s  ? rd_q + AW'(1) : rd_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_q] <= wdata;
        end
    end
endmodule

// File: rtl/trace_merge_unit.sv
// Multi-channel trace front end: timestamp, buffer per channel, round-robin merge, repeat lock.
// Optional TRACE_DROP_COUNT_EN adds per-channel 16-bit counters of records discarded while locked.
module trace_merge_unit
    import gouram_datatypes::*;
#(
    parameter int NUM_CHANNELS     = 2,
    parameter int RECORD_WIDTH     = 64,
    parameter int TIMESTAMP_WIDTH  = 32,
    parameter int FIFO_DEPTH       = 8,
    parameter int REPEAT_THRESHOLD = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    trace_merge_unit_if.slave          bus,
    input  logic                       lock_clear,
    output logic                       trace_capture_enable,
    output logic                       lock,
    output logic [TIMESTAMP_WIDTH-1:0] counter_o
`ifdef TRACE_DROP_COUNT_EN
    ,
    output logic [NUM_CHANNELS*16-1:0] drop_count_o
`endif
);
    localparam int CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int ENTRY_W = RECORD_WIDTH + TIMESTAMP_WIDTH;
    localparam int RCW     = $clog2(REPEAT_THRESHOLD + 1);
    localparam logic [RCW-1:0] THR = RCW'(REPEAT_THRESHOLD);

    logic [TIMESTAMP_WIDTH-1:0] counter_q, counter_d;
    logic                       lock_q, lock_d, cap_en_q, cap_en_d;
    logic [NUM_CHANNELS-1:0]    ready_s, push_s, pop_s, fifo_full_s, fifo_empty_s;
    logic [RECORD_WIDTH-1:0]    rec_s        [NUM_CHANNELS];
    logic [ENTRY_W-1:0]         fifo_rdata_s [NUM_CHANNELS];
    logic [RECORD_WIDTH-1:0]    last_rec_q   [NUM_CHANNELS];
    logic [RECORD_WIDTH-1:0]    last_rec_d   [NUM_CHANNELS];
    logic [RCW-1:0]             rep_cnt_q    [NUM_CHANNELS];
    logic [RCW-1:0]             rep_cnt_d    [NUM_CHANNELS];
    logic                       detect_s;
    logic [7:0]                 req_s;
    logic [3:0]                 pick_s;
    logic                       pop_ok_s;
    logic [ENTRY_W-1:0]         sel_entry_s;
    arb_ptr_t                   rr_ptr_q, rr_ptr_d;
    logic                       out_valid_q, out_valid_d;
    logic [RECORD_WIDTH-1:0]    out_data_q, out_data_d;
    logic [CH_W-1:0]            out_ch_q, out_ch_d;
    logic [TIMESTAMP_WIDTH-1:0] out_ts_q, out_ts_d;

    assign counter_o            = counter_q;
    assign lock                 = lock_q;
    assign trace_capture_enable = cap_en_q;
    assign bus.ch_ready         = ready_s;
    assign bus.trace_valid      = out_valid_q;
    assign bus.trace_data       = out_data_q;
    assign bus.trace_channel    = out_ch_q;
    assign bus.trace_timestamp  = out_ts_q;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        assign rec_s[g] = bus.ch_data[g*RECORD_WIDTH +: RECORD_WIDTH];

        trace_channel_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_s[g]),
            .pop   (pop_s[g]),
            .wdata ({rec_s[g], counter_q}),
            .rdata (fifo_rdata_s[g]),
            .full  (fifo_full_s[g]),
            .empty (fifo_empty_s[g])
        );
    end

    // Accept logic: locked channels are always ready so producers never stall
    always_comb begin
        ready_s = '0;
        push_s  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            ready_s[i] = !rst && (lock_q || !fifo_full_s[i]);
            push_s[i]  = bus.ch_valid[i] && ready_s[i] && !lock_q;
        end
    end

    // Repeat detection and lock control; lock_clear beats a same-cycle detection
    always_comb begin
        detect_s = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            last_rec_d[i] = last_rec_q[i];
            rep_cnt_d[i]  = rep_cnt_q[i];
            if (push_s[i]) begin
                last_rec_d[i] = rec_s[i];
                if ((rep_cnt_q[i] != '0) && (rec_s[i] == last_rec_q[i])) begin
                    rep_cnt_d[i] = (rep_cnt_q[i] == THR) ? THR : rep_cnt_q[i] + RCW'(1);
                end else begin
                    rep_cnt_d[i] = RCW'(1);
                end
                if ((rep_cnt_d[i] == THR) && (rep_cnt_q[i] != THR)) begin
                    detect_s = 1'b1;
                end
            end
            if (lock_clear) begin
                rep_cnt_d[i] = '0;
            end
        end
        if (lock_clear) begin
            lock_d = 1'b0;
        end else if (detect_s) begin
            lock_d = 1'b1;
        end else begin
            lock_d = lock_q;
        end
        cap_en_d  = !lock_d;
        counter_d = counter_q + TIMESTAMP_WIDTH'(1);
    end

    // Round-robin pop into the output register whenever it is free or being consumed
    always_comb begin
        req_s                    = '0;
        req_s[NUM_CHANNELS-1:0]  = ~fifo_empty_s;
        pop_ok_s                 = !out_valid_q || bus.trace_ready;
        pick_s                   = rr_pick(req_s, rr_ptr_q, NUM_CHANNELS);
        pop_s                    = '0;
        sel_entry_s              = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (pop_ok_s && pick_s[3] && (pick_s[2:0] == 3'(i))) begin
                pop_s[i]    = 1'b1;
                sel_entry_s = fifo_rdata_s[i];
            end
        end
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_ts_d    = out_ts_q;
        rr_ptr_d    = rr_ptr_q;
        if (pop_ok_s) begin
            out_valid_d = pick_s[3];
            if (pick_s[3]) begin
                out_data_d = sel_entry_s[ENTRY_W-1 -: RECORD_WIDTH];
                out_ts_d   = sel_entry_s[TIMESTAMP_WIDTH-1:0];
                out_ch_d   = pick_s[CH_W-1:0];
                rr_ptr_d   = (pick_s[2:0] == 3'(NUM_CHANNELS-1)) ? 3'd0 : pick_s[2:0] + 3'd1;
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; the counter resets to all-ones so the first live cycle reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_q   <= '1;
            lock_q      <= 1'b0;
            cap_en_q    <= 1'b1;
            rr_ptr_q    <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_ts_q    <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                last_rec_q[i] <= '0;
                rep_cnt_q[i]  <= '0;
            end
        end else begin
            counter_q   <= counter_d;
            lock_q      <= lock_d;
            cap_en_q    <= cap_en_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_ts_q    <= out_ts_d;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                last_rec_q[i] <= last_rec_d[i];
                rep_cnt_q[i]  <= rep_cnt_d[i];
            end
        end
    end

`ifdef TRACE_DROP_COUNT_EN
    logic [15:0] drop_q [NUM_CHANNELS];
    logic [15:0] drop_d [NUM_CHANNELS];

    // Saturating count of records swallowed while locked
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (lock_clear) begin
                drop_d[i] = 16'd0;
            end else if (lock_q && bus.ch_valid[i] && ready_s[i] && (drop_q[i] != 16'hFFFF)) begin
                drop_d[i] = drop_q[i] + 16'd1;
            end else begin
                drop_d[i] = drop_q[i];
            end
        end
    end

    // Drop counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                drop_q[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                drop_q[i] <= drop_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_drop
        assign drop_count_o[g*16 +: 16] = drop_q[g];
    end
`endif
endmodule

// File: tb/tb_trace_merge_unit.sv
// Directed bench for trace_merge_unit with a per-channel scoreboard and a narrow-timestamp instance.
module tb_trace_merge_unit;
    logic clk;
    logic rst;
    logic lock_clear;
    logic cap_o, lock_o, cap2_o, lock2_o;
    logic [31:0] counter_o;
    logic [3:0]  counter2_o;
`ifdef TRACE_DROP_COUNT_EN
    logic [31:0] drop_o, drop2_o;
`endif

    trace_merge_unit_if #(.NUM_CHANNELS(2), .RECORD_WIDTH(64), .TIMESTAMP_WIDTH(32)) bif ();
    trace_merge_unit_if #(.NUM_CHANNELS(2), .RECORD_WIDTH(64), .TIMESTAMP_WIDTH(4))  b2 ();

    trace_merge_unit #(.NUM_CHANNELS(2), .RECORD_WIDTH(64), .TIMESTAMP_WIDTH(32),
                       .FIFO_DEPTH(8), .REPEAT_THRESHOLD(4)) dut (
        .clk(clk), .rst(rst), .bus(bif), .lock_clear(lock_clear),
        .trace_capture_enable(cap_o), .lock(lock_o), .counter_o(counter_o)
`ifdef TRACE_DROP_COUNT_EN
        , .drop_count_o(drop_o)
`endif
    );

    trace_merge_unit #(.NUM_CHANNELS(2), .RECORD_WIDTH(64), .TIMESTAMP_WIDTH(4),
                       .FIFO_DEPTH(8), .REPEAT_THRESHOLD(4)) dut2 (
        .clk(clk), .rst(rst), .bus(b2), .lock_clear(lock_clear),
        .trace_capture_enable(cap2_o), .lock(lock2_o), .counter_o(counter2_o)
`ifdef TRACE_DROP_COUNT_EN
        , .drop_count_o(drop2_o)
`endif
    );

    typedef struct packed {
        logic [63:0] rec;
        logic [31:0] ts;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          ch_log[$];
    int          n_assert, n_fail;
    logic [31:0] cnt_m;
    logic        lock_m;
    int          rep_m[2];
    logic [63:0] last_m[2];
    logic [15:0] drop_m[2];
    int          out_cnt[2];
    logic [31:0] ts_p;
    int          pushes, guard;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: score handshakes and consumptions seen now, then advance past the next edge.
    task automatic tick();
        logic [63:0] r;
        logic        nl;
        logic        have;
        exp_t        e;
        check("counter", 128'(counter_o), 128'(cnt_m));
        check("lock", 128'(lock_o), 128'(lock_m));
        check("capture_en", 128'(cap_o), 128'(!lock_m));
        nl = lock_m;
        for (int i = 0; i < 2; i++) begin
            if (bif.ch_valid[i] && bif.ch_ready[i]) begin
                r = bif.ch_data[i*64 +: 64];
                if (lock_m) begin
                    if (drop_m[i] != 16'hFFFF) drop_m[i] = drop_m[i] + 16'd1;
                end else begin
                    e.rec = r;
                    e.ts  = cnt_m;
                    if (i == 0) q0.push_back(e); else q1.push_back(e);
                    if (rep_m[i] != 0 && r == last_m[i]) begin
                        if (rep_m[i] < 4) rep_m[i]++;
                    end else begin
                        rep_m[i] = 1;
                    end
                    last_m[i] = r;
                    if (rep_m[i] == 4) nl = 1'b1;
                end
            end
        end
        if (lock_clear) begin
            nl = 1'b0;
            rep_m[0] = 0; rep_m[1] = 0;
            drop_m[0] = 16'd0; drop_m[1] = 16'd0;
        end
        if (bif.trace_valid && bif.trace_ready) begin
            ch_log.push_back(int'(bif.trace_channel));
            out_cnt[bif.trace_channel]++;
            if (bif.trace_channel == 1'b0) begin
                have = (q0.size() != 0);
                if (have) e = q0.pop_front();
            end else begin
                have = (q1.size() != 0);
                if (have) e = q1.pop_front();
            end
            check("sb_expected_present", 128'(have), 128'(1));
            if (have) begin
                check("trace_data", 128'(bif.trace_data), 128'(e.rec));
                check("trace_timestamp", 128'(bif.trace_timestamp), 128'(e.ts));
            end
        end
        @(posedge clk);
        #1;
        cnt_m  = cnt_m + 32'd1;
        lock_m = nl;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q0.size() != 0 || q1.size() != 0 || bif.trace_valid) && g < 100) begin
            tick();
            g++;
        end
        check("drain_empty", 128'(q0.size() + q1.size()), 128'(0));
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        rst = 1'b1; lock_clear = 1'b0;
        bif.ch_valid = 2'b00; bif.ch_data = '0; bif.trace_ready = 1'b0;
        b2.ch_valid  = 2'b00; b2.ch_data  = '0; b2.trace_ready  = 1'b1;
        cnt_m = 32'hFFFF_FFFF; lock_m = 1'b0;
        rep_m[0] = 0; rep_m[1] = 0; last_m[0] = '0; last_m[1] = '0;
        drop_m[0] = 16'd0; drop_m[1] = 16'd0; out_cnt[0] = 0; out_cnt[1] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_trace_valid", 128'(bif.trace_valid), 128'(0));
        check("rst_trace_data", 128'(bif.trace_data), 128'(0));
        check("rst_trace_channel", 128'(bif.trace_channel), 128'(0));
        check("rst_trace_ts", 128'(bif.trace_timestamp), 128'(0));
        check("rst_counter", 128'(counter_o), 128'(32'hFFFF_FFFF));
        check("rst_counter_narrow", 128'(counter2_o), 128'(4'hF));
        check("rst_lock", 128'(lock_o), 128'(0));
        check("rst_capture_en", 128'(cap_o), 128'(1));
        check("rst_ch_ready", 128'(bif.ch_ready), 128'(0));
        rst = 1'b0;

        // Single record in cycle 5 appears in cycle 7
        bif.trace_ready = 1'b1;
        while (cnt_m != 32'd5) tick();
        bif.ch_valid = 2'b01;
        bif.ch_data[63:0] = 64'hA5A5_0000_0000_0001;
        tick();
        bif.ch_valid = 2'b00;
        check("lat_cycle6_valid", 128'(bif.trace_valid), 128'(0));
        tick();
        check("lat_cycle7_valid", 128'(bif.trace_valid), 128'(1));
        check("lat_cycle7_ts", 128'(bif.trace_timestamp), 128'(5));
        check("lat_cycle7_ch", 128'(bif.trace_channel), 128'(0));
        check("lat_cycle7_data", 128'(bif.trace_data), 128'(64'hA5A5_0000_0000_0001));
        drain();

        // Both channels every cycle: grants alternate, starting after last grant (channel 0)
        ch_log.delete();
        for (int k = 0; k < 12; k++) begin
            bif.ch_valid = 2'b11;
            bif.ch_data  = {64'h1111_0000_0000_0000 | 64'(k), 64'h0C0C_0000_0000_0000 | 64'(k)};
            tick();
        end
        bif.ch_valid = 2'b00;
        drain();
        check("alt_count", 128'(ch_log.size()), 128'(24));
        for (int j = 0; j < 10 && j < ch_log.size(); j++) begin
            check("alt_channel", 128'(ch_log[j]), 128'((j + 1) % 2));
        end

        // Back-pressure: output register held, channel 1 fills to depth
        bif.trace_ready = 1'b0;
        bif.ch_valid = 2'b01;
        bif.ch_data[63:0] = 64'h0000_0000_0000_BEEF;
        ts_p = cnt_m;
        tick();
        bif.ch_valid = 2'b00;
        tick();
        tick();
        check("stall_valid", 128'(bif.trace_valid), 128'(1));
        pushes = 0; guard = 0;
        while (pushes < 8 && guard < 40) begin
            bif.ch_valid = 2'b10;
            bif.ch_data[127:64] = 64'h0000_0000_0000_B000 + 64'(pushes);
            if (bif.ch_ready[1]) pushes++;
            tick();
            guard++;
        end
        bif.ch_valid = 2'b00;
        check("bp_pushes", 128'(pushes), 128'(8));
        check("bp_ch1_ready", 128'(bif.ch_ready[1]), 128'(0));
        check("bp_ch0_ready", 128'(bif.ch_ready[0]), 128'(1));
        check("bp_stable_valid", 128'(bif.trace_valid), 128'(1));
        check("bp_stable_data", 128'(bif.trace_data), 128'(64'h0000_0000_0000_BEEF));
        check("bp_stable_ts", 128'(bif.trace_timestamp), 128'(ts_p));
        check("bp_stable_ch", 128'(bif.trace_channel), 128'(0));
        bif.trace_ready = 1'b1;
        drain();

        // Four identical records lock the unit; further records are discarded
        out_cnt[0] = 0; out_cnt[1] = 0;
        for (int k = 0; k < 4; k++) begin
            bif.ch_valid = 2'b01;
            bif.ch_data[63:0] = 64'h5EED_5EED_5EED_5EED;
            tick();
        end
        check("lock_set", 128'(lock_o), 128'(1));
        check("lock_capture_off", 128'(cap_o), 128'(0));
        check("lock_ready_all", 128'(bif.ch_ready), 128'(2'b11));
        for (int k = 0; k < 3; k++) tick();
        bif.ch_valid = 2'b00;
        drain();
        check("lock_outputs", 128'(out_cnt[0]), 128'(4));
`ifdef TRACE_DROP_COUNT_EN
        check("drop_count_ch0", 128'(drop_o[15:0]), 128'(drop_m[0]));
        check("drop_count_ch0_three", 128'(drop_o[15:0]), 128'(3));
`endif

        // Clearing the lock restarts the repeat count
        lock_clear = 1'b1;
        tick();
        lock_clear = 1'b0;
        check("clear_lock", 128'(lock_o), 128'(0));
        check("clear_capture_on", 128'(cap_o), 128'(1));
        out_cnt[0] = 0;
        for (int k = 0; k < 3; k++) begin
            bif.ch_valid = 2'b01;
            bif.ch_data[63:0] = 64'h5EED_5EED_5EED_5EED;
            tick();
        end
        bif.ch_valid = 2'b00;
        check("no_relock", 128'(lock_o), 128'(0));
        drain();
        check("clear_outputs", 128'(out_cnt[0]), 128'(3));
`ifdef TRACE_DROP_COUNT_EN
        check("drop_count_cleared", 128'(drop_o[15:0]), 128'(0));
`endif

        // Narrow timestamp wraps from 15 to 0
        while (cnt_m[3:0] != 4'hF) tick();
        check("wrap_counter", 128'(counter2_o), 128'(4'hF));
        b2.ch_valid = 2'b01;
        b2.ch_data[63:0] = 64'h0000_0000_0000_0F15;
        tick();
        b2.ch_data[63:0] = 64'h0000_0000_0000_0F00;
        tick();
        b2.ch_valid = 2'b00;
        check("wrap_first_valid", 128'(b2.trace_valid), 128'(1));
        check("wrap_first_ts", 128'(b2.trace_timestamp), 128'(15));
        check("wrap_first_data", 128'(b2.trace_data), 128'(64'h0F15));
        tick();
        check("wrap_second_ts", 128'(b2.trace_timestamp), 128'(0));
        check("wrap_second_data", 128'(b2.trace_data), 128'(64'h0F00));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
